// File: rtl/vga_raster_driver_pkg.sv
// Shared timing defaults, bus widths and helper types for the VGA raster driver.
// VGA_TEST_PATTERN_EN: when defined, the top module uses bar_colour() below.
package vga_raster_driver_pkg;

    // 640x480@60 default timing (pixels / lines)
    localparam int HORIZONTAL_WIDTH_PIXELS = 640;
    localparam int H_FRONT_PORCH           = 16;
    localparam int H_SYNC_PULSE            = 96;
    localparam int H_BACK_PORCH            = 48;

    localparam int VERTICAL_HEIGHT_PIXELS  = 480;
    localparam int V_FRONT_PORCH           = 10;
    localparam int V_SYNC_PULSE            = 2;
    localparam int V_BACK_PORCH            = 33;

    // Bus widths
    localparam int COORD_W  = 10;
    localparam int COLOUR_W = 8;

    // Timing flags that travel with a coordinate until its colour arrives.
    // All-zero means blank, no sync, so a cleared pipe is the idle state.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
    } timing_flags_t;

    // Colour of one of the 8 vertical bars, packed {r, g, b}.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [3*COLOUR_W-1:0] bar_colour(input logic [2:0] bar);
        bar_colour = {{COLOUR_W{~bar[1]}}, {COLOUR_W{~bar[2]}}, {COLOUR_W{~bar[0]}}};
    endfunction

endpackage

// File: rtl/signal_delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
// DEPTH=0 degenerates to a plain wire.
module signal_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        // Clock and reset have no job in the passthrough case.
        logic unused_clk_rst;
        assign unused_clk_rst = clock_i ^ reset_n_i;
        assign data_o         = data_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift register: stage 0 takes the input, each later stage its predecessor.
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_raster_driver.sv
// VGA raster timing master: issues pixel coordinates to a pixel source, takes
// the colour back PIXEL_LATENCY cycles later and drives ADV7123 DAC pins with
// sync/blank delayed to match. Pin latency is PIXEL_LATENCY+1 cycles.
// VGA_TEST_PATTERN_EN: replace the source colour by 8 vertical colour bars.
module vga_raster_driver
    import vga_raster_driver_pkg::*;
#(
    parameter int H_VISIBLE     = HORIZONTAL_WIDTH_PIXELS,
    parameter int H_FRONT       = H_FRONT_PORCH,
    parameter int H_SYNC        = H_SYNC_PULSE,
    parameter int H_BACK        = H_BACK_PORCH,
    parameter int V_VISIBLE     = VERTICAL_HEIGHT_PIXELS,
    parameter int V_FRONT       = V_FRONT_PORCH,
    parameter int V_SYNC        = V_SYNC_PULSE,
    parameter int V_BACK        = V_BACK_PORCH,
    parameter int PIXEL_LATENCY = 1     // 0..4
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic [COLOUR_W-1:0] red_i,
    input  logic [COLOUR_W-1:0] green_i,
    input  logic [COLOUR_W-1:0] blue_i,
    output logic [COORD_W-1:0]  x_pixel_coord_o,
    output logic [COORD_W-1:0]  y_pixel_coord_o,
    output logic                is_inside_visible_region_o,
    output logic                frame_start_o,
    output logic [COLOUR_W-1:0] vga_r_o,
    output logic [COLOUR_W-1:0] vga_g_o,
    output logic [COLOUR_W-1:0] vga_b_o,
    output logic                vga_hsync_n_o,
    output logic                vga_vsync_n_o,
    output logic                vga_blank_n_o,
    output logic                vga_sync_n_o,
    output logic                vga_clk_o
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam int RGB_W = 3 * COLOUR_W;

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;

    timing_flags_t flags_now;
    timing_flags_t flags_dly;

    logic [COLOUR_W-1:0] src_r, src_g, src_b;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_n_q;
    logic             vsync_n_q;
    logic             blank_n_q;

    // Raster counters: h every cycle, v on each line wrap, both wrap at TOTAL-1.
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Counter registers; reset puts the raster back at (0,0) immediately.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Sync and visibility decoded from the counters at coordinate time.
    // Visible is gated by reset so the source sees an idle raster while held.
    always_comb begin
        flags_now.hsync   = (h_q >= HS_START) && (h_q < HS_END);
        flags_now.vsync   = (v_q >= VS_START) && (v_q < VS_END);
        flags_now.visible = reset_n_i && (h_q < H_VIS_END) && (v_q < V_VIS_END);
    end

    assign x_pixel_coord_o            = h_q;
    assign y_pixel_coord_o            = v_q;
    assign is_inside_visible_region_o = flags_now.visible;
    assign frame_start_o              = reset_n_i && (h_q == '0) && (v_q == '0);

    // Hold the flags back until the matching colour comes out of the source.
    signal_delay_line #(
        .WIDTH ($bits(timing_flags_t)),
        .DEPTH (PIXEL_LATENCY)
    ) u_flag_delay (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .data_i    (flags_now),
        .data_o    (flags_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0]       bar_now;
    logic [2:0]       bar_dly;
    logic [RGB_W-1:0] pattern_rgb;
    logic             unused_source;

    // Bar index by threshold compare, avoiding a divider on the counter.
    always_comb begin
        bar_now = '0;
        for (int k = 1; k < 8; k++) begin
            if (h_q >= COORD_W'(k * BAR_W)) begin
                bar_now = 3'(k);
            end
        end
    end

    // Bar index travels alongside the flags so the pattern lines up with sync.
    signal_delay_line #(
        .WIDTH (3),
        .DEPTH (PIXEL_LATENCY)
    ) u_bar_delay (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .data_i    (bar_now),
        .data_o    (bar_dly)
    );

    assign pattern_rgb   = bar_colour(bar_dly);
    assign src_r         = pattern_rgb[RGB_W-1 -: COLOUR_W];
    assign src_g         = pattern_rgb[2*COLOUR_W-1 -: COLOUR_W];
    assign src_b         = pattern_rgb[COLOUR_W-1:0];
    assign unused_source = ^{red_i, green_i, blue_i};
`else
    assign src_r = red_i;
    assign src_g = green_i;
    assign src_b = blue_i;
`endif

    // Source colour is only passed on inside the visible window.
    always_comb begin
        rgb_d = '0;
        if (flags_dly.visible) begin
            rgb_d = {src_r, src_g, src_b};
        end
    end

    // Single output register joining colour with the delayed sync/blank.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rgb_q     <= '0;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            rgb_q     <= rgb_d;
            hsync_n_q <= ~flags_dly.hsync;
            vsync_n_q <= ~flags_dly.vsync;
            blank_n_q <= flags_dly.visible;
        end
    end

    assign vga_r_o       = rgb_q[RGB_W-1 -: COLOUR_W];
    assign vga_g_o       = rgb_q[2*COLOUR_W-1 -: COLOUR_W];
    assign vga_b_o       = rgb_q[COLOUR_W-1:0];
    assign vga_hsync_n_o = hsync_n_q;
    assign vga_vsync_n_o = vsync_n_q;
    assign vga_blank_n_o = blank_n_q;
    assign vga_sync_n_o  = 1'b0;
    // DAC latches on the falling pixel-clock edge, mid-way through our data.
    assign vga_clk_o     = ~clock_i;

endmodule

// File: tb/tb_vga_raster_driver.sv
// Self-checking bench for vga_raster_driver.
// Three instances: full 640x480 timing at latency 1, and a reduced raster
// (24x12 total) at latencies 0 and 3 so frame wrap fits a short run.
module tb_vga_raster_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] green_c = 8'hFF;
    logic [7:0] blue_c  = 8'h5A;

    // full-timing instance, latency 1
    logic [9:0] f_x, f_y;
    logic       f_vis, f_fs, f_hs, f_vs, f_bl, f_sy, f_ck;
    logic [7:0] f_r, f_g, f_b;
    logic [7:0] f_src_q;

    // reduced instance, latency 0
    logic [9:0] a_x, a_y;
    logic       a_vis, a_fs, a_hs, a_vs, a_bl, a_sy, a_ck;
    logic [7:0] a_r, a_g, a_b;

    // reduced instance, latency 3
    logic [9:0] b_x, b_y;
    logic       b_vis, b_fs, b_hs, b_vs, b_bl, b_sy, b_ck;
    logic [7:0] b_r, b_g, b_b;
    logic [7:0] b_s0_q, b_s1_q, b_s2_q;

    // Pixel source models: red = x[7:0] returned after the instance's latency.
    always @(posedge clk) begin
        f_src_q <= f_x[7:0];
        b_s0_q  <= b_x[7:0];
        b_s1_q  <= b_s0_q;
        b_s2_q  <= b_s1_q;
    end

    vga_raster_driver #(.PIXEL_LATENCY(1)) u_full (
        .clock_i(clk), .reset_n_i(rst_n),
        .red_i(f_src_q), .green_i(green_c), .blue_i(blue_c),
        .x_pixel_coord_o(f_x), .y_pixel_coord_o(f_y),
        .is_inside_visible_region_o(f_vis), .frame_start_o(f_fs),
        .vga_r_o(f_r), .vga_g_o(f_g), .vga_b_o(f_b),
        .vga_hsync_n_o(f_hs), .vga_vsync_n_o(f_vs), .vga_blank_n_o(f_bl),
        .vga_sync_n_o(f_sy), .vga_clk_o(f_ck)
    );

    vga_raster_driver #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIXEL_LATENCY(0)
    ) u_lat0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .red_i(a_x[7:0]), .green_i(green_c), .blue_i(blue_c),
        .x_pixel_coord_o(a_x), .y_pixel_coord_o(a_y),
        .is_inside_visible_region_o(a_vis), .frame_start_o(a_fs),
        .vga_r_o(a_r), .vga_g_o(a_g), .vga_b_o(a_b),
        .vga_hsync_n_o(a_hs), .vga_vsync_n_o(a_vs), .vga_blank_n_o(a_bl),
        .vga_sync_n_o(a_sy), .vga_clk_o(a_ck)
    );

    vga_raster_driver #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIXEL_LATENCY(3)
    ) u_lat3 (
        .clock_i(clk), .reset_n_i(rst_n),
        .red_i(b_s2_q), .green_i(green_c), .blue_i(blue_c),
        .x_pixel_coord_o(b_x), .y_pixel_coord_o(b_y),
        .is_inside_visible_region_o(b_vis), .frame_start_o(b_fs),
        .vga_r_o(b_r), .vga_g_o(b_g), .vga_b_o(b_b),
        .vga_hsync_n_o(b_hs), .vga_vsync_n_o(b_vs), .vga_blank_n_o(b_bl),
        .vga_sync_n_o(b_sy), .vga_clk_o(b_ck)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
        bit vis;
        bit fs;
        bit hs_n;
        bit blank_n;
        int r;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    int f_first_low, f_low_cnt, a_fs_cnt, a_vs_low, mask_err, found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step1();
        @(negedge clk);
        #1;
        cur++;
    endtask

    task automatic step_to(input int n);
        while (cur < n) step1();
    endtask

    initial begin
        // cyc, x, y, vis, fs, hsync_n pin, blank_n pin, red pin (pins lag 2 cycles)
        vecs[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vecs[1]  = '{1,    1,   0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{2,    2,   0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        vecs[3]  = '{3,    3,   0, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        vecs[4]  = '{639,  639, 0, 1'b1, 1'b0, 1'b1, 1'b1, 125};
        vecs[5]  = '{640,  640, 0, 1'b0, 1'b0, 1'b1, 1'b1, 126};
        vecs[6]  = '{641,  641, 0, 1'b0, 1'b0, 1'b1, 1'b1, 127};
        vecs[7]  = '{642,  642, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[8]  = '{657,  657, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[9]  = '{658,  658, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{753,  753, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[11] = '{754,  754, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[12] = '{799,  799, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[13] = '{800,  0,   1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[14] = '{802,  2,   1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        vecs[15] = '{1600, 0,   2, 1'b1, 1'b0, 1'b1, 1'b0, 0};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        check("rst_x",       32'(f_x),   0);
        check("rst_y",       32'(f_y),   0);
        check("rst_vis",     32'(f_vis), 0);
        check("rst_fs",      32'(f_fs),  0);
        check("rst_hsync_n", 32'(f_hs),  1);
        check("rst_vsync_n", 32'(f_vs),  1);
        check("rst_blank_n", 32'(f_bl),  0);
        check("rst_r",       32'(f_r),   0);
        check("sync_n_tied", 32'(f_sy),  0);
        check("vga_clk_inv", 32'(f_ck),  1);
        $display("reset: x=%0d y=%0d vis=%0b fs=%0b hs_n=%0b vs_n=%0b blank_n=%0b", f_x, f_y, f_vis, f_fs, f_hs, f_vs, f_bl);

        // release between edges; this sample is cycle 0
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cur = 0;

        // ---- table of directed vectors on the full-timing instance ----
        for (int i = 0; i < NVEC; i++) begin
            step_to(vecs[i].cyc);
            $display("vec %0d cyc=%0d x=%0d y=%0d vis=%0b fs=%0b hs_n=%0b blank_n=%0b r=%0d",
                     i, cur, f_x, f_y, f_vis, f_fs, f_hs, f_bl, f_r);
            check("vec_x",       32'(f_x),   32'(vecs[i].x));
            check("vec_y",       32'(f_y),   32'(vecs[i].y));
            check("vec_vis",     32'(f_vis), 32'(vecs[i].vis));
            check("vec_fs",      32'(f_fs),  32'(vecs[i].fs));
            check("vec_hsync_n", 32'(f_hs),  32'(vecs[i].hs_n));
            check("vec_blank_n", 32'(f_bl),  32'(vecs[i].blank_n));
            check("vec_vsync_n", 32'(f_vs),  1);
`ifndef VGA_TEST_PATTERN_EN
            check("vec_r",       32'(f_r),   32'(vecs[i].r));
`endif
        end

        // ---- hsync pulse width/position on line 2, plus green masking ----
        f_first_low = -1;
        f_low_cnt   = 0;
        mask_err    = 0;
        while (cur < 2400) begin
            if (!f_hs) begin
                if (f_first_low < 0) f_first_low = cur;
                f_low_cnt++;
            end
            if (!f_bl && f_g != 8'h00) mask_err++;
`ifndef VGA_TEST_PATTERN_EN
            if (f_bl && f_g != 8'hFF) mask_err++;
`endif
            step1();
        end
        $display("line2 hsync: first_low=%0d low_cycles=%0d", f_first_low, f_low_cnt);
        check("hsync_start_line2", 32'(f_first_low), 2258);
        check("hsync_width_line2", 32'(f_low_cnt),   96);
        check("green_mask_line2",  32'(mask_err),    0);

        // ---- asynchronous reset mid-frame at (300,3) ----
        found = 0;
        for (int k = 0; k < 5000 && found == 0; k++) begin
            if (f_x == 300 && f_y == 3) found = 1;
            else step1();
        end
        check("reach_300_3", 32'(found), 1);
        #1;
        rst_n = 1'b0;   // between edges
        #1;
        $display("midreset: x=%0d y=%0d vis=%0b blank_n=%0b r=%0d hs_n=%0b", f_x, f_y, f_vis, f_bl, f_r, f_hs);
        check("mrst_x",       32'(f_x),   0);
        check("mrst_y",       32'(f_y),   0);
        check("mrst_vis",     32'(f_vis), 0);
        check("mrst_fs",      32'(f_fs),  0);
        check("mrst_blank_n", 32'(f_bl),  0);
        check("mrst_r",       32'(f_r),   0);
        check("mrst_hsync_n", 32'(f_hs),  1);
        check("mrst_vsync_n", 32'(f_vs),  1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        #1;
        cur = 0;

        // ---- post-release run: full line 0, reduced-raster frames and latency ----
        f_first_low = -1;
        f_low_cnt   = 0;
        a_fs_cnt    = 0;
        a_vs_low    = 0;
        mask_err    = 0;
        for (int c = 0; c <= 800; c++) begin
            if (c > 0) step1();
            if (c < 800 && !f_hs) begin
                if (f_first_low < 0) f_first_low = c;
                f_low_cnt++;
            end
            if (c < 600 && a_fs) a_fs_cnt++;
            if (c >= 1 && c <= 288 && !a_vs) a_vs_low++;
            if (!a_bl && a_r != 8'h00) mask_err++;
            if (!b_bl && b_r != 8'h00) mask_err++;
            if (!f_bl && (f_r != 8'h00 || f_g != 8'h00 || f_b != 8'h00)) mask_err++;

            case (c)
                0: begin
                    check("post_fs",      32'(f_fs),  1);
                    check("post_x",       32'(f_x),   0);
                    check("post_vis",     32'(f_vis), 1);
                    check("lat0_blank_c0", 32'(a_bl), 0);
                end
                1: begin
                    check("lat0_blank_c1", 32'(a_bl), 1);
                    check("post_fs_c1",    32'(f_fs), 0);
`ifndef VGA_TEST_PATTERN_EN
                    check("lat0_r_c1",     32'(a_r),  0);
`endif
                end
                2: begin
`ifndef VGA_TEST_PATTERN_EN
                    check("lat0_r_c2",     32'(a_r),  1);
                    check("full_b_c2",     32'(f_b),  32'h5A);
                    check("full_g_c2",     32'(f_g),  32'hFF);
`else
                    check("pat_x0",  32'({f_r, f_g, f_b}), 32'hFFFFFF);
`endif
                end
                3: check("lat3_blank_c3", 32'(b_bl), 0);
                4: begin
                    check("lat3_blank_c4", 32'(b_bl), 1);
`ifndef VGA_TEST_PATTERN_EN
                    check("lat3_r_c4",     32'(b_r),  0);
`endif
                end
                5: begin
`ifndef VGA_TEST_PATTERN_EN
                    check("lat3_r_c5",     32'(b_r),  1);
`endif
                end
`ifdef VGA_TEST_PATTERN_EN
                82:  check("pat_x80",  32'({f_r, f_g, f_b}), 32'hFFFF00);
                562: check("pat_x560", 32'({f_r, f_g, f_b}), 32'h000000);
`endif
                287: begin
                    check("small_x_c287",  32'(a_x),  23);
                    check("small_y_c287",  32'(a_y),  11);
                    check("small_fs_c287", 32'(a_fs), 0);
                end
                288: begin
                    check("small_x_c288",  32'(a_x),  0);
                    check("small_y_c288",  32'(a_y),  0);
                    check("small_fs_c288", 32'(a_fs), 1);
                    check("small3_fs_c288", 32'(b_fs), 1);
                end
                576: check("small_fs_c576", 32'(a_fs), 1);
                default: ;
            endcase
        end
        $display("post-release: hsync first_low=%0d low_cycles=%0d small_fs=%0d small_vs_low=%0d mask_err=%0d",
                 f_first_low, f_low_cnt, a_fs_cnt, a_vs_low, mask_err);
        check("hsync_start_line0", 32'(f_first_low), 658);
        check("hsync_width_line0", 32'(f_low_cnt),   96);
        check("small_fs_count",    32'(a_fs_cnt),    3);
        check("small_vsync_width", 32'(a_vs_low),    48);
        check("blank_rgb_mask",    32'(mask_err),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
